// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and srl sequencer:
// op codes, sequencer states and funct bit positions.
package alu_ctrl_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] OP_AND    = 4'b0000;
    localparam logic [CODE_W-1:0] OP_OR     = 4'b0001;
    localparam logic [CODE_W-1:0] OP_ADD    = 4'b0010;
    localparam logic [CODE_W-1:0] OP_SRL1   = 4'b0011;
    localparam logic [CODE_W-1:0] OP_PASS_A = 4'b0100;
    localparam logic [CODE_W-1:0] OP_SRL4   = 4'b0101;
    localparam logic [CODE_W-1:0] OP_SUB    = 4'b0110;
    localparam logic [CODE_W-1:0] OP_SLT    = 4'b0111;

    localparam int F0 = 0;
    localparam int F1 = 1;
    localparam int F2 = 2;
    localparam int F3 = 3;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational aluop/funct decode to an ALU op code; flags the R-type srl
// so the sequencer can take over multi-step shifts.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [3:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CODE_W-1:0]  code,
    output logic               is_srl
);

    logic f0, f1, f2, f3;
    logic unused_funct;

    assign f0 = funct[F0];
    assign f1 = funct[F1];
    assign f2 = funct[F2];
    assign f3 = funct[F3];
    // Only the low nibble of funct participates in the decode.
    assign unused_funct = ^funct[FUNCT_W-1:4];

    always_comb begin
        code   = OP_ADD;
        is_srl = 1'b0;
        if (aluop[3]) begin
            code = OP_OR;
        end else if (aluop[2]) begin
            code = OP_ADD;
        end else if (aluop[1]) begin
            if (f1 && f0) begin
                code   = OP_SRL1;
                is_srl = 1'b1;
            end else if (f2 && !f0) begin
                code = OP_AND;
            end else if (f2 && f0) begin
                code = OP_OR;
            end else if (f1 && !f3) begin
                code = OP_SUB;
            end else if (f1 && f3) begin
                code = OP_SLT;
            end else begin
                code = OP_ADD;
            end
        end else if (aluop[0]) begin
            code = OP_SUB;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with an srl sequencer that splits variable shifts into
// single-step ALU passes. Define ALUCTL_FASTSHIFT_EN to also use 4-bit steps.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = 5,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [3:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [CTRL_W-1:0]  gout,
    output logic               fb_sel,
    output logic               stall,
    output logic               done
);

    logic [CODE_W-1:0]  dec_code, code, sh_code;
    logic               is_srl;
    state_e             state, state_n;
    logic [SHAMT_W-1:0] rem, rem_n, amt, step, left;
    logic               fb, stl, dn;

    alu_ctrl_dec #(.FUNCT_W(FUNCT_W)) u_dec (
        .aluop  (aluop),
        .funct  (funct),
        .code   (dec_code),
        .is_srl (is_srl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    // Step size depends only on the amount still to shift, never on stall.
    always_comb begin
        amt = (state == SHIFT) ? rem : shamt;
`ifdef ALUCTL_FASTSHIFT_EN
        if (amt >= SHAMT_W'(4)) begin
            step    = SHAMT_W'(4);
            sh_code = OP_SRL4;
        end else begin
            step    = SHAMT_W'(1);
            sh_code = OP_SRL1;
        end
`else
        step    = SHAMT_W'(1);
        sh_code = OP_SRL1;
`endif
        left = amt - step;
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        code    = dec_code;
        fb      = 1'b0;
        stl     = 1'b0;
        dn      = 1'b0;
        case (state)
            IDLE: begin
                dn = req;
                if (is_srl) begin
                    if (shamt == '0) begin
                        code = OP_PASS_A;
                    end else begin
                        code = sh_code;
                        if (req && left != '0) begin
                            stl     = 1'b1;
                            dn      = 1'b0;
                            rem_n   = left;
                            state_n = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                code  = sh_code;
                fb    = 1'b1;
                rem_n = left;
                if (left != '0) begin
                    stl = 1'b1;
                end else begin
                    dn      = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are held at a safe ADD/no-stall value for as long as reset is low.
    always_comb begin
        gout   = CTRL_W'(OP_ADD);
        fb_sel = 1'b0;
        stall  = 1'b0;
        done   = 1'b0;
        if (rst_n) begin
            gout   = CTRL_W'(code);
            fb_sel = fb;
            stall  = stl;
            done   = dn;
        end
    end

endmodule
